z_fetch: RTL and testbench

Z_FETCH -- requirements
Module: z_fetch

---
 rtl/z_pkg.sv | 15 +
 rtl/z_fetch_fifo.sv | 57 +++++
 rtl/z_fetch.sv | 98 +++++++++
 tb/tb_z_fetch.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z_pkg.sv
// Shared fetch-stage types and constants for the z_* core.
package z_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;
    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] pc);
        return {pc[WORD_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/z_fetch_fifo.sv
// Instruction queue between the memory response port and decode.
// Flush has priority over push and pop; storage itself is not reset.
module z_fetch_fifo
    import z_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     rdata,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);
    fetch_entry_t     slots [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = slots[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) slots[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/z_fetch.sv
// Instruction fetch: credit-limited request issue, in-order response capture,
// and redirect handling that marks every outstanding request stale.
module z_fetch
    import z_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [WORD_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [WORD_W-1:0] imem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_pc,
    output logic [WORD_W-1:0] out_inst
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [WORD_W-1:0] fetch_pc;
    logic [WORD_W-1:0] rsp_pc;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  inflight_next;
    logic [CNT_W-1:0]  stale;
    logic [CNT_W-1:0]  live;
    logic [CNT_W-1:0]  fifo_count;
    logic [SUM_W-1:0]  used;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              req_fire;
    logic              stale_rsp;
    logic              live_rsp;
    fetch_entry_t      head;
    fetch_entry_t      rsp_entry;

    // A same-cycle pop frees its slot, which is what sustains one
    // instruction per cycle at the minimum depth and latency.
    assign pop  = out_valid && out_ready;
    assign live = inflight - stale;
    assign used = SUM_W'(fifo_count) + SUM_W'(live) - SUM_W'(pop);

    assign imem_req_valid = !rst && (used < SUM_W'(DEPTH)) && !(fifo_full && !pop);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign stale_rsp     = imem_rsp_valid && (stale != '0);
    assign live_rsp      = imem_rsp_valid && (stale == '0) && !redirect;
    assign inflight_next = inflight + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

    assign rsp_entry = '{pc: rsp_pc, inst: imem_rsp_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= align_pc(RESET_PC);
            rsp_pc   <= align_pc(RESET_PC);
            inflight <= '0;
            stale    <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect) begin
                // Everything still outstanding after this edge belongs to the old path.
                fetch_pc <= align_pc(redirect_pc);
                rsp_pc   <= align_pc(redirect_pc);
                stale    <= inflight_next;
            end else begin
                if (req_fire)  fetch_pc <= fetch_pc + PC_STEP;
                if (live_rsp)  rsp_pc   <= rsp_pc + PC_STEP;
                if (stale_rsp) stale    <= stale - CNT_W'(1);
            end
        end
    end

    z_fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (live_rsp),
        .pop  (pop),
        .flush(redirect),
        .wdata(rsp_entry),
        .rdata(head),
        .empty(fifo_empty),
        .full (fifo_full),
        .count(fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_pc    = out_valid ? head.pc   : '0;
    assign out_inst  = out_valid ? head.inst : '0;
endmodule

// File: tb/tb_z_fetch.sv
// Scoreboard bench for z_fetch: directed stimulus pushes expected entries,
// a negedge monitor pops and compares every delivered instruction.
module tb_z_fetch;
    import z_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;
    localparam int          TB_DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ndeliv   = 0;
    int nreq     = 0;
    int lat      = 1;
    int t0;
    int n0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t        pend[$];
    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;
    logic [31:0]  exp_pc;

    z_fetch #(
        .RESET_PC(TB_RESET_PC),
        .DEPTH   (TB_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_inst      (out_inst)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst);
        exp_q.push_back('{pc: pc, inst: inst});
    endtask

    task automatic exp_seq(input int n);
        for (int i = 0; i < n; i++) begin
            push_exp(exp_pc, img(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic take(input int n);
        int target;
        int budget;
        target    = ndeliv + n;
        budget    = 0;
        out_ready = 1'b1;
        while (ndeliv < target && budget < 60) begin
            @(posedge clk);
            #1;
            budget++;
        end
        out_ready = 1'b0;
        check("take_count", 32'(ndeliv), 32'(target));
    endtask

    // Memory model: always in order, fixed latency lat, one response per cycle.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst && imem_req_valid && imem_req_ready) begin
                pend.push_back('{addr: imem_req_addr, due: cyc + lat});
                nreq++;
            end
            @(posedge clk);
            #1;
            if (rst) begin
                pend.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end else if (pend.size() != 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = img(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                ndeliv++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL out_unexpected actual pc=%h inst=%h required none", out_pc, out_inst);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (out_pc !== mon_e.pc || out_inst !== mon_e.inst) begin
                        failures++;
                        $display("FAIL out_entry actual pc=%h inst=%h required pc=%h inst=%h",
                                 out_pc, out_inst, mon_e.pc, mon_e.inst);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        rst = 1'b0;
        #1;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, TB_RESET_PC);

        // Reset-release stream across the 2^32 wrap, one per cycle.
        push_exp(32'hFFFF_FFF8, 32'hFFF8_0007);
        push_exp(32'hFFFF_FFFC, 32'hFFFC_0003);
        push_exp(32'h0000_0000, 32'h0000_FFFF);
        push_exp(32'h0000_0004, 32'h0004_FFFB);
        push_exp(32'h0000_0008, 32'h0008_FFF7);
        push_exp(32'h0000_000C, 32'h000C_FFF3);
        t0 = cyc;
        take(6);
        check("stream_cycles", 32'(cyc - t0), 32'd8);
        exp_pc = 32'h0000_0010;

        // Consumer stall for 10 cycles.
        n0 = nreq;
        repeat (10) @(posedge clk);
        #1;
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_issue_le_depth", 32'(nreq - n0 <= TB_DEPTH), 32'd1);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        exp_seq(4);
        take(4);

        // Redirect in the same cycle as a pop and a live response.
        push_exp(exp_pc, img(exp_pc));
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        out_ready   = 1'b1;
        @(negedge clk);
        check("pre_rsp_valid", 32'(imem_rsp_valid), 32'd1);
        check("pre_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        redirect  = 1'b0;
        out_ready = 1'b0;
        check("post_redirect_out_valid", 32'(out_valid), 32'd0);
        exp_pc = 32'h0000_0200;
        exp_seq(2);
        take(2);

        // Latency 3: two requests in flight when redirected to 0x100.
        lat = 3;
        repeat (8) @(posedge clk);
        #1;
        n0          = nreq;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0000;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("lat3_inflight", 32'(nreq - n0), 32'd2);
        check("lat3_credit_stop", 32'(imem_req_valid), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        check("lat3_new_addr", imem_req_addr, 32'h0000_0100);
        check("lat3_new_valid", 32'(imem_req_valid), 32'd1);
        check("lat3_drop0", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat3_drop1", 32'(out_valid), 32'd0);
        exp_pc = 32'h0000_0100;
        exp_seq(3);
        take(3);

        // Back-to-back redirects: only the last target is fetched.
        lat         = 1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        @(posedge clk);
        #1;
        redirect_pc = 32'h0000_0000;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        push_exp(32'h0000_0000, 32'h0000_FFFF);
        push_exp(32'h0000_0004, 32'h0004_FFFB);
        push_exp(32'h0000_0008, 32'h0008_FFF7);
        push_exp(32'h0000_000C, 32'h000C_FFF3);
        take(4);

        // Asynchronous reset between clock edges.
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        check("pre_async_out_valid", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_out_pc", out_pc, 32'd0);
        check("async_out_inst", out_inst, 32'd0);
        check("async_req_valid", 32'(imem_req_valid), 32'd0);
        check("pre_reset_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        rst            = 1'b0;
        #1;
        check("restart_addr", imem_req_addr, TB_RESET_PC);
        repeat (3) @(posedge clk);
        #1;
        check("hold_valid", 32'(imem_req_valid), 32'd1);
        check("hold_addr", imem_req_addr, TB_RESET_PC);
        imem_req_ready = 1'b1;
        exp_pc         = TB_RESET_PC;
        exp_seq(3);
        take(3);

        repeat (3) @(posedge clk);
        #1;
        check("exp_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
